usb_ep_tx_arbiter: RTL

- Shares the single SIE transmit byte path among NUM_EP endpoint transmit requesters.
- Uses round-robin grant with packet-level locking, so one granted endpoint owns the path until its last byte is sent.
- Enforces a minimum inter-packet gap, and aborts a packet if its endpoint stalls mid-packet.
- Sits between the endpoint buffers and usb_sie, in the clk48 domain.

---
 rtl/usb_ep_tx_arbiter_if.sv | 37 +++
 rtl/usb_ep_tx_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/usb_ep_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_tx_arbiter_if
// Brief    : Endpoint-request / SIE-transmit bundle for usb_ep_tx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface usb_ep_tx_arbiter_if #(
    parameter int NUM_EP = 4
);
    logic [NUM_EP-1:0]   ep_req;
    logic [NUM_EP*8-1:0] ep_data;
    logic [NUM_EP-1:0]   ep_valid;
    logic [NUM_EP-1:0]   ep_last;
    logic [NUM_EP-1:0]   ep_ready;
    logic [NUM_EP-1:0]   ep_grant;
    logic [7:0]          sie_tx_data;
    logic                sie_tx_valid;
    logic                sie_tx_last;
    logic                sie_tx_ready;
    logic                sie_tx_abort;
    logic                busy;

    // Environment side: endpoint buffers plus the SIE ready return.
    modport master (
        output ep_req, ep_data, ep_valid, ep_last, sie_tx_ready,
        input  ep_ready, ep_grant, sie_tx_data, sie_tx_valid, sie_tx_last,
               sie_tx_abort, busy
    );

    // Arbiter side.
    modport slave (
        input  ep_req, ep_data, ep_valid, ep_last, sie_tx_ready,
        output ep_ready, ep_grant, sie_tx_data, sie_tx_valid, sie_tx_last,
               sie_tx_abort, busy
    );
endinterface
`default_nettype wire

// File: rtl/usb_ep_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_tx_arbiter
// Brief    : Round-robin, packet-locked sharing of the SIE TX byte path with
//            inter-packet gap and mid-packet stall abort.
// Revision : 1.0  initial release
// ============================================================================
module usb_ep_tx_arbiter #(
    parameter int NUM_EP        = 4,
    parameter int IPG_CYCLES    = 8,
    parameter int STALL_TIMEOUT = 64
) (
    input wire            clk48,
    input wire            rst,
    usb_ep_tx_arbiter_if.slave bus
);
    localparam int PTR_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int GAP_W   = $clog2(IPG_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_TIMEOUT);

    localparam logic [PTR_W-1:0]   C_LAST_EP     = PTR_W'(NUM_EP - 1);
    localparam logic [GAP_W-1:0]   C_GAP_LOAD    = GAP_W'(IPG_CYCLES);
    localparam logic [GAP_W-1:0]   C_GAP_ONE     = GAP_W'(1);
    localparam logic [STALL_W-1:0] C_STALL_LIMIT = STALL_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr;
    logic [PTR_W-1:0]    r_gidx;
    logic [NUM_EP-1:0]   r_grant;
    logic [GAP_W-1:0]    r_gap;
    logic [STALL_W-1:0]  r_stall;
    logic                r_abort;

    logic [PTR_W-1:0]    w_sel;
    logic [NUM_EP-1:0]   w_sel_onehot;
    logic                w_any_req;
    logic [PTR_W-1:0]    w_next_rr;
    logic                w_streaming;
    logic                w_valid;
    logic                w_xfer;
    logic                w_timeout;

    // First requester at or above the round-robin pointer, wrapping.
    always_comb begin
        w_sel        = r_rr;
        w_any_req    = 1'b0;
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (!w_any_req && bus.ep_req[(int'(r_rr) + i) % NUM_EP]) begin
                w_any_req = 1'b1;
                w_sel     = PTR_W'((int'(r_rr) + i) % NUM_EP);
            end
        end
        for (int i = 0; i < NUM_EP; i++) begin
            w_sel_onehot[i] = (w_sel == PTR_W'(i));
        end
    end

    assign w_next_rr   = (r_gidx == C_LAST_EP) ? '0 : r_gidx + 1'b1;
    assign w_streaming = (r_state == S_STREAM);
    assign w_valid     = bus.ep_valid[r_gidx];
    assign w_xfer      = w_streaming && w_valid && bus.sie_tx_ready;
    assign w_timeout   = w_streaming && !w_xfer && (r_stall == C_STALL_LIMIT);

    assign bus.sie_tx_data  = w_streaming ? bus.ep_data[{r_gidx, 3'b000} +: 8] : 8'h00;
    assign bus.sie_tx_valid = w_streaming && w_valid;
    assign bus.sie_tx_last  = w_streaming && w_valid && bus.ep_last[r_gidx];
    assign bus.ep_ready     = (w_streaming && bus.sie_tx_ready) ? r_grant : '0;
    assign bus.ep_grant     = r_grant;
    assign bus.sie_tx_abort = r_abort;
    assign bus.busy         = (r_state != S_IDLE);

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_gap   <= '0;
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_stall <= '0;
                    if (w_any_req) begin
                        r_gidx  <= w_sel;
                        r_grant <= w_sel_onehot;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_stall <= '0;
                    end else if (r_stall != '1) begin
                        r_stall <= r_stall + 1'b1;
                    end
                    // A transfer on the threshold cycle suppresses the abort.
                    if ((w_xfer && bus.ep_last[r_gidx]) || w_timeout) begin
                        r_abort <= w_timeout;
                        r_grant <= '0;
                        r_rr    <= w_next_rr;
                        r_gap   <= C_GAP_LOAD;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 1'b1;
                    if (r_gap == C_GAP_ONE) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_grant_legal: assert property (@(posedge clk48) disable iff (rst)
        $onehot0(r_grant) && ((r_state == S_STREAM) || (r_grant == '0)));

endmodule
`default_nettype wire
